// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Buffered 8N1 serial transmitter for the CPU serial data port. Bytes written
// on a one-cycle strobe are queued and shifted out LSB first on txd, one
// start bit, eight data bits and one stop bit, each DIV = CLK_FREQ / BAUD
// clocks long. Frames are sent back to back with no idle gap while bytes
// remain queued.
//
// Build option:
//   UART_TX_FIFO_EN  defined   -> 2^FIFO_AW entry FIFO in front of the shifter
//                    undefined -> single holding register (full = holding valid,
//                                 level is 0 or 1, FIFO_AW only sizes level)
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (aborts any frame in flight)
//   wr_en    in   write strobe; accepted when full is low
//   wr_data  in   byte to queue
//   full     out  registered queue-full flag
//   busy     out  frame in progress or bytes queued
//   level    out  bytes queued, excluding the frame on the wire
//   ovf      out  sticky: a write arrived while full (cleared only by rst)
//   txd      out  registered serial output, idle high
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) on the line
// DATA  | data bit sh_q[0] on the line, bitn_q counts 0..7
// STOP  | stop bit (high); pops the next byte directly into START if queued

module uart_tx_buffered #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic               busy,
    output logic [FIFO_AW:0]   level,
    output logic               ovf,
    output logic               txd
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int LW  = FIFO_AW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitn_q, bitn_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;
    logic          ovf_q;

    logic          accept;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    head_data;
    logic          cnt_done;

    // Acceptance is judged on the registered full flag only, so a pop in the
    // same cycle never rescues a write that arrives while full.
    assign accept = wr_en & ~full;

    // ------------------------------------------------------------------
    // Byte queue
    // ------------------------------------------------------------------
`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               full_q;

    always_comb begin
        level_d = level_q;
        if (accept && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!accept && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign fifo_empty = (level_q == '0);
    assign level      = level_q;
    assign full       = full_q;
`else
    logic [7:0] hold_q;
    logic       valid_q;

    // accept needs !valid_q and pop needs valid_q, so they never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= 8'h00;
            valid_q <= 1'b0;
        end else if (accept) begin
            hold_q  <= wr_data;
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign head_data  = hold_q;
    assign fifo_empty = ~valid_q;
    assign level      = {{FIFO_AW{1'b0}}, valid_q};
    assign full       = valid_q;
`endif

    // ------------------------------------------------------------------
    // Framing FSM. The baud timer is a down-counter loaded with DIV-1 at
    // the start of each bit; the bit ends on the edge that sees it at 0.
    // txd_d is the line value for the state being entered, so txd is a
    // plain register with no path from wr_en.
    // ------------------------------------------------------------------
    assign cnt_done = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bitn_d  = bitn_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = head_data;
                    cnt_d   = CNT_LAST;
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (cnt_done) begin
                    cnt_d   = CNT_LAST;
                    bitn_d  = 3'd0;
                    state_d = S_DATA;
                    txd_d   = sh_q[0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_done) begin
                    sh_d  = {1'b0, sh_q[7:1]};
                    cnt_d = CNT_LAST;
                    if (bitn_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bitn_d = bitn_q + 3'd1;
                        txd_d  = sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        sh_d    = head_data;
                        cnt_d   = CNT_LAST;
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bitn_q  <= 3'd0;
            sh_q    <= 8'h00;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_q | (wr_en & full);
        end
    end

    assign txd  = txd_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != S_IDLE) | (level != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       busy;
    logic [4:0] level;
    logic       ovf;
    logic       txd;

    int tests;
    int fails;
    int cyc;
    int k0;

    uart_tx_buffered #(
        .CLK_FREQ(1000),
        .BAUD    (100),
        .FIFO_AW (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .busy   (busy),
        .level  (level),
        .ovf    (ovf),
        .txd    (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Checks a 100-cycle frame of byte b from bit-cycle index 'start' onward;
    // the current sample is index 'start', and one tick follows each check.
    task automatic frame_check(input logic [7:0] b, input int start, input string tag);
        for (int i = start; i < 100; i++) begin
            int   bi;
            logic e;
            bi = i / 10;
            if (bi == 0)      e = 1'b0;
            else if (bi == 9) e = 1'b1;
            else              e = b[bi-1];
            chk(tag, {30'd0, busy, txd}, {30'd0, 1'b1, e});
            tick();
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // 1: idle after reset, {txd,busy,full,ovf,level}
        for (int i = 0; i < 50; i++) begin
            chk("idle", {23'd0, txd, busy, full, ovf, level}, {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
            tick();
        end

        // 2: single byte 0xA5
        wr_data = 8'hA5;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("a5_level_k", {27'd0, level}, 32'd1);
        chk("a5_txd_k", {31'd0, txd}, 32'd1);
        chk("a5_busy_k", {31'd0, busy}, 32'd1);
        tick();
        chk("a5_level_k1", {27'd0, level}, 32'd0);
        frame_check(8'hA5, 0, "a5_frame");
        chk("a5_busy_end", {31'd0, busy}, 32'd0);
        chk("a5_txd_end", {31'd0, txd}, 32'd1);
        tick();

        // Two frames back to back, second byte written once the first is popped
        wr_data = 8'h96;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("b2b_level_k", {27'd0, level}, 32'd1);
        tick();
        chk("b2b_txd_k1", {31'd0, txd}, 32'd0);
        chk("b2b_level_k1", {27'd0, level}, 32'd0);
        wr_data = 8'h3C;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("b2b_level_k2", {27'd0, level}, 32'd1);
        chk("b2b_ovf", {31'd0, ovf}, 32'd0);
        frame_check(8'h96, 1, "b2b_frame0");
        frame_check(8'h3C, 0, "b2b_frame1");
        chk("b2b_busy_end", {31'd0, busy}, 32'd0);
        tick();

`ifdef UART_TX_FIFO_EN
        // 3: three consecutive writes, level peaks at 2
        wr_data = 8'h55;
        wr_en   = 1'b1;
        tick();
        chk("s3_level_k", {27'd0, level}, 32'd1);
        wr_data = 8'h0F;
        tick();
        chk("s3_level_k1", {27'd0, level}, 32'd1);
        chk("s3_txd_k1", {31'd0, txd}, 32'd0);
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        chk("s3_level_k2", {27'd0, level}, 32'd2);
        chk("s3_full", {31'd0, full}, 32'd0);
        frame_check(8'h55, 1, "s3_frame0");
        frame_check(8'h0F, 0, "s3_frame1");
        frame_check(8'hFF, 0, "s3_frame2");
        chk("s3_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // 4: 18-byte burst, 0x11 dropped
        for (int j = 0; j < 18; j++) begin
            wr_data = 8'(j);
            wr_en   = 1'b1;
            tick();
            chk("s4_level", {27'd0, level}, (j == 0) ? 32'd1 : (j > 16) ? 32'd16 : 32'(j));
            chk("s4_full", {31'd0, full}, (j >= 16) ? 32'd1 : 32'd0);
        end
        wr_en = 1'b0;
        chk("s4_ovf", {31'd0, ovf}, 32'd1);
        frame_check(8'h00, 16, "s4_frame");
        for (int j = 1; j <= 16; j++) begin
            frame_check(8'(j), 0, "s4_frame");
        end
        chk("s4_busy_end", {31'd0, busy}, 32'd0);
        chk("s4_txd_end", {31'd0, txd}, 32'd1);
        chk("s4_ovf_sticky", {31'd0, ovf}, 32'd1);
        tick();
`else
        // 6: holding register, second write while full is dropped
        wr_data = 8'h31;
        wr_en   = 1'b1;
        tick();
        chk("s6_full_k", {31'd0, full}, 32'd1);
        chk("s6_level_k", {27'd0, level}, 32'd1);
        chk("s6_ovf_k", {31'd0, ovf}, 32'd0);
        wr_data = 8'h32;
        tick();
        wr_en = 1'b0;
        chk("s6_ovf", {31'd0, ovf}, 32'd1);
        chk("s6_level_k1", {27'd0, level}, 32'd0);
        chk("s6_full_k1", {31'd0, full}, 32'd0);
        frame_check(8'h31, 0, "s6_frame");
        for (int i = 0; i < 20; i++) begin
            chk("s6_no_second", {30'd0, busy, txd}, {30'd0, 1'b0, 1'b1});
            tick();
        end
        chk("s6_ovf_sticky", {31'd0, ovf}, 32'd1);
`endif

        // 5: reset during data bit 3 with bytes queued
        wr_data = 8'h08;
        wr_en   = 1'b1;
        tick();
        k0    = cyc;
        wr_en = 1'b0;
        tick();
        wr_data = 8'h5A;
        wr_en   = 1'b1;
        tick();
`ifdef UART_TX_FIFO_EN
        wr_data = 8'hC3;
        tick();
`endif
        wr_en = 1'b0;
        while (cyc < k0 + 44) tick();
        chk("s5_bit3", {31'd0, txd}, 32'd1);
`ifdef UART_TX_FIFO_EN
        chk("s5_level_pre", {27'd0, level}, 32'd2);
`else
        chk("s5_level_pre", {27'd0, level}, 32'd1);
`endif
        chk("s5_ovf_pre", {31'd0, ovf}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_txd", {31'd0, txd}, 32'd1);
        chk("s5_level", {27'd0, level}, 32'd0);
        chk("s5_busy", {31'd0, busy}, 32'd0);
        chk("s5_ovf", {31'd0, ovf}, 32'd0);
        chk("s5_full", {31'd0, full}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("s5_quiet", {29'd0, txd, busy, ovf}, {29'd0, 1'b1, 1'b0, 1'b0});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered 8N1 serial transmitter: the transmit end of the CPU's serial data port. The memory-map decoder writes bytes on a one-cycle strobe when the CPU stores to the serial data address. Bytes are queued in a FIFO and shifted out on `txd` at a fixed baud rate. `full` and `busy` feed the serial status word read by software.

## Interface
Parameters:
- `CLK_FREQ`, default 50000000: clock frequency in Hz.
- `BAUD`, default 9600: line rate. Bit period `DIV = CLK_FREQ / BAUD`, integer-truncated; 5208 at the defaults. `DIV` must be ≥ 2.
- `FIFO_AW`, default 4: FIFO address width. Depth = 2^FIFO_AW = 16 entries.

Ports:
- `clk`  in  1  system clock (clk_50M).
- `rst`  in  1  reset: synchronous, active-high.
- `wr_en`  in  1  write strobe, sampled on the rising edge of `clk`.
- `wr_data`  in  8  byte to send, captured when `wr_en` is accepted.
- `full`  out  1  FIFO full (registered); software treats `!full` as TX-ready.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `level`  out  FIFO_AW+1  number of bytes queued, excluding the frame on the wire.
- `ovf`  out  1  sticky overflow flag.
- `txd`  out  1  serial line output, idle high.

## Operation
FIFO:
- A write is accepted when `wr_en=1` and `full=0`, judged on the registered `full` value.
- A write with `full=1` is dropped and sets `ovf`. This holds even if a pop occurs in the same cycle.
- A simultaneous accepted write and pop leaves `level` unchanged.
- Read/write pointers wrap modulo the depth. `full` asserts when `level == 2^FIFO_AW`.

FSM, with bit counter `bitn` (3 bits) and baud counter `cnt` (counts 0..DIV-1):
- IDLE: `txd=1`. If the FIFO is non-empty, pop the head into the shift register `sh`, set `cnt=0`, and go to START.
- START: `txd=0`. When `cnt == DIV-1`, set `cnt=0`, `bitn=0`, and go to DATA.
- DATA: `txd=sh[0]`, sent LSB first. When `cnt == DIV-1`, shift `sh` right and set `cnt=0`. If `bitn == 7` go to STOP, otherwise increment `bitn`.
- STOP: `txd=1`. When `cnt == DIV-1`: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.

Outputs:
- `txd` is driven from a register; no combinational path from `wr_en` to `txd`.
- `busy = (state != IDLE) | (level != 0)`.

Reset:
- Values after reset: `txd=1`, `full=0`, `busy=0`, `level=0`, `ovf=0`, state IDLE, all counters 0, FIFO pointers 0.
- `rst` asserted mid-frame aborts the frame: `txd=1` on the next edge and queued bytes are discarded. A truncated frame on the line is acceptable.
- `ovf` is cleared only by `rst`.

## Timing
- Write accepted at edge k → `level` increments at edge k. The FSM pops at edge k+1 → `txd` falls at edge k+1 when starting from IDLE.
- Frame length is exactly 10·DIV cycles: start bit, 8 data bits, stop bit.
- Back-to-back frames are contiguous. The next start bit begins the cycle after the stop bit's last cycle.
- `full`, `level` and `ovf` reflect the accept/pop events of edge k starting at edge k.
- Sustained throughput is one byte per 10·DIV cycles. Bursts of up to 2^FIFO_AW bytes are absorbed without loss; a burst of 2^FIFO_AW + 1 is also absorbed if the first pop has already occurred.

## Configuration
Macro `UART_TX_FIFO_EN`:
- Defined: the FIFO is as described above, with depth 2^FIFO_AW.
- Undefined: the FIFO is replaced by a single holding register.
  - `full` equals holding-valid.
  - `level` is 0 or 1.
  - `FIFO_AW` is ignored.
  - Framing, timing, `ovf` and reset behaviour are unchanged.

## Test plan
All scenarios use `CLK_FREQ=1000` and `BAUD=100`, giving DIV=10.

1. Reset, then hold idle for 50 cycles → `txd=1`, `busy=0`, `level=0`, `full=0` throughout.
2. Write 0xA5 once → `txd` falls 1 cycle after the write. The line then carries 0, 1,0,1,0,0,1,0,1, 1 (start, data LSB first, stop), each held exactly 10 cycles. `busy` drops 100 cycles after `txd` falls.
3. Write 0x55, 0x0F, 0xFF on 3 consecutive cycles → three contiguous frames totalling 300 cycles with no idle gap between them. `level` peaks at 2.
4. With FIFO_EN, write 18 bytes 0x00–0x11 on consecutive cycles → bytes 0x00–0x10 are transmitted in order. 0x11 is dropped, `ovf=1`, and `full=1` is seen for at least one cycle.
5. Assert `rst` during data bit 3 of a frame with 2 bytes queued → `txd=1` from the next edge, then `level=0`, `busy=0`, `ovf=0`. No further frames are sent.
6. Without FIFO_EN, write 0x31 and then 0x32 on consecutive cycles → the holding register accepts 0x31, `full=1` on the cycle 0x32 is presented, 0x32 is dropped, and `ovf=1`.
